// File: rtl/seq_add_pkg.sv
// Shared definitions for the nibble-serial adder: FSM encoding and step-count sizing.
package seq_add_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam int SLICE_W = 4;

  function automatic int nib_of(input int width);
    return width / SLICE_W;
  endfunction

  function automatic int cnt_w_of(input int nib);
    return (nib > 1) ? $clog2(nib) : 1;
  endfunction

endpackage

// File: rtl/seq_add16_cla4.sv
// 4-bit carry-lookahead slice; also exposes the carry into bit 3 for overflow detection.
module CLA_4bit (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  input  logic       i_cin,
  output logic [3:0] o_sum,
  output logic       o_cout,
  output logic       o_c3
);

  logic [3:0] w_g;
  logic [3:0] w_p;
  logic [4:0] w_c;

  assign w_g = i_a & i_b;
  assign w_p = i_a ^ i_b;

  assign w_c[0] = i_cin;
  assign w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
  assign w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);

  assign o_sum  = w_p ^ w_c[3:0];
  assign o_cout = w_c[4];
  assign o_c3   = w_c[3];

endmodule

// File: rtl/seq_add16.sv
// Nibble-serial adder: one 4-bit CLA slice reused over WIDTH/4 cycles, valid/ready on both sides.
module seq_add16
  import seq_add_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NIB = nib_of(WIDTH);
  localparam int CW  = cnt_w_of(NIB);

  state_t           r_state;
  state_t           w_next;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic [3:0]       w_slice_sum;
  logic             w_slice_cout;
  logic             w_slice_c3;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_acc_next;

  CLA_4bit u_slice (
    .i_a    (r_a[3:0]),
    .i_b    (r_b[3:0]),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout),
    .o_c3   (w_slice_c3)
  );

  assign w_last     = (r_cnt == CW'(NIB - 1));
  assign w_accept   = (r_state == S_IDLE) && in_valid;
  // Slice result enters at the top; after NIB steps the first nibble sits at bit 0.
  assign w_acc_next = WIDTH'({w_slice_sum, r_acc} >> 4);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (in_valid)  w_next = S_RUN;
      S_RUN:   if (w_last)    w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_cnt   <= '0;
        r_carry <= cin;
      end else if (r_state == S_RUN) begin
        r_cnt   <= r_cnt + CW'(1);
        r_carry <= w_slice_cout;
        if (w_last) begin
          r_sum  <= w_acc_next;
          r_cout <= w_slice_cout;
          r_ovf  <= w_slice_c3 ^ w_slice_cout;
        end
      end
    end
  end

  // Operand/partial-sum shifters carry no control meaning, so they skip reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_a <= a;
      r_b <= b;
    end else if (r_state == S_RUN) begin
      r_a   <= r_a >> 4;
      r_b   <= r_b >> 4;
      r_acc <= w_acc_next;
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_seq_add16.sv
// Directed and randomized checks of seq_add16 with a result scoreboard.
module tb_seq_add16;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   n_vec;
  int   n_miss;
  res_t sb[$];

  seq_add16 #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  function automatic res_t model(input logic [15:0] x, input logic [15:0] y, input logic ci);
    logic [16:0] full;
    logic [15:0] low;
    res_t r;
    full = {1'b0, x} + {1'b0, y} + {16'd0, ci};
    low  = {1'b0, x[14:0]} + {1'b0, y[14:0]} + {15'd0, ci};
    r.s = full[15:0];
    r.c = full[16];
    r.o = low[15] ^ full[16];
    return r;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
      $error("%s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mk(input logic [15:0] s, input logic c, input logic o, output res_t r);
    r.s = s;
    r.c = c;
    r.o = o;
  endtask

  task automatic send(input logic [15:0] x, input logic [15:0] y, input logic ci,
                      input logic push, input res_t e);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    chk("send_ready", 32'(in_ready), 32'd1);
    a = x;
    b = y;
    cin = ci;
    in_valid = 1'b1;
    if (push) sb.push_back(e);
    tick();
    in_valid = 1'b0;
    chk("busy_after_accept", 32'(in_ready), 32'd0);
  endtask

  task automatic compare_head(input string tag);
    res_t e;
    chk({tag, "_sb"}, 32'(sb.size() != 0), 32'd1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_sum"}, 32'(sum), 32'(e.s));
      chk({tag, "_cout"}, 32'(cout), 32'(e.c));
      chk({tag, "_ovf"}, 32'(ovf), 32'(e.o));
    end
  endtask

  task automatic await_result(input string tag);
    int lat;
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd4);
    compare_head(tag);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("ready_after_consume", 32'(in_ready), 32'd1);
    chk("ovalid_after_consume", 32'(out_valid), 32'd0);
  endtask

  initial begin
    res_t e;
    int   sent;
    int   recv;
    int   cyc;
    int   last;

    n_vec = 0;
    n_miss = 0;
    rst = 1'b1;
    in_valid = 1'b1;
    out_ready = 1'b0;
    a = 16'hAAAA;
    b = 16'h5555;
    cin = 1'b1;

    // reset, with in_valid asserted to show reset wins
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    rst = 1'b0;
    in_valid = 1'b0;
    tick();
    chk("idle_after_rst", 32'(in_ready), 32'd1);

    // directed arithmetic cases
    mk(16'h5555, 1'b0, 1'b0, e);
    send(16'h1234, 16'h4321, 1'b0, 1'b1, e);
    await_result("add_1234");
    consume();

    mk(16'h0000, 1'b1, 1'b0, e);
    send(16'hFFFF, 16'h0000, 1'b1, 1'b1, e);
    await_result("ripple_ffff");
    consume();

    mk(16'h8000, 1'b0, 1'b1, e);
    send(16'h7FFF, 16'h0001, 1'b0, 1'b1, e);
    await_result("ovf_pos");
    consume();

    mk(16'h0000, 1'b1, 1'b1, e);
    send(16'h8000, 16'h8000, 1'b0, 1'b1, e);
    await_result("ovf_neg");
    consume();

    // stall in DONE, with in_valid pulses and operand changes after accept
    mk(16'h1000, 1'b0, 1'b0, e);
    send(16'h0F0F, 16'h00F1, 1'b0, 1'b1, e);
    in_valid = 1'b1;
    a = 16'hFFFF;
    b = 16'hFFFF;
    cin = 1'b1;
    await_result("stall");
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      a = 16'(i * 16'h1111);
      tick();
      chk("stall_ovalid", 32'(out_valid), 32'd1);
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      chk("stall_sum", 32'(sum), 32'h1000);
    end
    in_valid = 1'b0;
    consume();
    chk("hold_sum_idle", 32'(sum), 32'h1000);

    // reset in the second RUN cycle abandons the operation
    send(16'h1111, 16'h2222, 1'b0, 1'b0, e);
    tick();
    chk("prev_sum_during_run", 32'(sum), 32'h1000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midrun_rst_in_ready", 32'(in_ready), 32'd1);
    chk("midrun_rst_out_valid", 32'(out_valid), 32'd0);
    chk("midrun_rst_sum", 32'(sum), 32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("abandoned_no_result", 32'(out_valid), 32'd0);
    end
    mk(16'h0000, 1'b1, 1'b0, e);
    send(16'h0001, 16'hFFFF, 1'b0, 1'b1, e);
    await_result("after_rst");
    consume();

    // reset in DONE beats out_ready and clears the result
    send(16'h0003, 16'h0004, 1'b0, 1'b0, e);
    for (int i = 0; i < 4; i++) tick();
    chk("pre_rst_done_sum", 32'(sum), 32'h0007);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    chk("done_rst_out_valid", 32'(out_valid), 32'd0);
    chk("done_rst_sum", 32'(sum), 32'd0);
    chk("done_rst_in_ready", 32'(in_ready), 32'd1);

    // back-to-back random traffic
    sent = 0;
    recv = 0;
    cyc = 0;
    last = -1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    while (recv < 1000 && cyc < 8000) begin
      if (out_valid) begin
        compare_head("b2b");
        if (last >= 0) chk("b2b_period", 32'(cyc - last), 32'd6);
        last = cyc;
        recv++;
      end
      if (in_ready) begin
        if (sent < 1000) begin
          a = 16'($urandom);
          b = 16'($urandom);
          cin = 1'($urandom);
          sb.push_back(model(a, b, cin));
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end else begin
        a = 16'($urandom);
        b = 16'($urandom);
        cin = 1'($urandom);
      end
      tick();
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 32'(recv), 32'd1000);
    chk("sb_empty_end", 32'(sb.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
